// File: rtl/seq_div_4bit_pkg.sv
// Shared types and defaults for the sequential restoring divider.
// Holds the FSM state encoding and the default operand width.
package seq_div_4bit_pkg;

    localparam int DIV_WIDTH = 4;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } div_state_e;

endpackage

// File: rtl/seq_div_4bit_step.sv
// One combinational restoring-division step.
// Ports: r/q/d = partial remainder, quotient shift reg, divisor;
//        r_next/q_next = values after one shift-and-trial-subtract.
module seq_div_4bit_step #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] r,
    input  logic [WIDTH-1:0] q,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] r_next,
    output logic [WIDTH-1:0] q_next
);

    logic [WIDTH-1:0] r_sh;
    logic [WIDTH:0]   trial;

    // Before any step r holds at most WIDTH-1 significant bits,
    // so dropping r[WIDTH-1] in the shift loses nothing.
    assign r_sh  = {r[WIDTH-2:0], q[WIDTH-1]};
    assign trial = {1'b0, r_sh} - {1'b0, d};

    always_comb begin
        r_next = r_sh;
        q_next = {q[WIDTH-2:0], 1'b0};
        if (!trial[WIDTH]) begin
            r_next = trial[WIDTH-1:0];
            q_next = {q[WIDTH-2:0], 1'b1};
        end
    end

endmodule

// File: rtl/seq_div_4bit.sv
// Sequential unsigned restoring divider, one bit per cycle.
// Ports: clk, reset (sync, active-high), start, dividend, divisor in;
//        busy, done (1-cycle pulse), quotient, remainder, div_by_zero out.
module seq_div_4bit
    import seq_div_4bit_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH) + 1;

    div_state_e       state;
    div_state_e       state_nxt;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] d_q;
    logic [WIDTH-1:0] r_nxt;
    logic [WIDTH-1:0] q_nxt;
    logic             accept;
    logic             last;
    logic             dz;

    seq_div_4bit_step #(
        .WIDTH (WIDTH)
    ) u_div_step (
        .r      (r_q),
        .q      (q_q),
        .d      (d_q),
        .r_next (r_nxt),
        .q_next (q_nxt)
    );

    // DONE accepts a new start just like IDLE, giving back-to-back ops.
    assign accept = start && (state != S_RUN);
    assign last   = (cnt == CW'(WIDTH - 1));
    assign dz     = (divisor == '0);

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        unique case (state)
            S_IDLE, S_DONE: begin
                done      = (state == S_DONE);
                state_nxt = S_IDLE;
                if (start)
                    state_nxt = dz ? S_DONE : S_RUN;
            end
            S_RUN: begin
                busy = 1'b1;
                if (last)
                    state_nxt = S_DONE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_IDLE;
            cnt         <= '0;
            r_q         <= '0;
            q_q         <= '0;
            d_q         <= '0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                d_q <= divisor;
                q_q <= dividend;
                r_q <= '0;
                cnt <= '0;
                // Divide-by-zero skips RUN, so its result lands now.
                if (dz) begin
                    quotient    <= '1;
                    remainder   <= dividend;
                    div_by_zero <= 1'b1;
                end
            end else if (state == S_RUN) begin
                r_q <= r_nxt;
                q_q <= q_nxt;
                cnt <= cnt + CW'(1);
                if (last) begin
                    cnt         <= '0;
                    quotient    <= q_nxt;
                    remainder   <= r_nxt;
                    div_by_zero <= 1'b0;
                end
            end
        end
    end

endmodule
